// File: rtl/if_id_stall_buffer.sv
// if_id_stall_buffer: PC register and IF/ID pipeline buffer driven by the
// hazard-control signals (PC_Write, IF_ID_Write, IF_ID_flush, Wrong_prediction).
// A small FSM tracks stall episodes, and a watchdog flags stalls that run too long.
// Optional feature macro: PERF_CNT_EN builds the stall/flush performance counters.
module if_id_stall_buffer #(
  parameter int unsigned XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INST   = 32'h00000013,
  parameter int unsigned WDOG_LIMIT = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_Write,
  input  logic            IF_ID_Write,
  input  logic            IF_ID_flush,
  input  logic            Wrong_prediction,
  input  logic [XLEN-1:0] Branch_target,
  input  logic            JR_valid,
  input  logic [XLEN-1:0] JR_target,
  input  logic [31:0]     IF_inst,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] ID_PC,
  output logic [31:0]     ID_inst,
  output logic            ID_valid,
  output logic [1:0]      Stall_state,
  output logic            Stall_timeout,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    JR_WAIT  = 2'd2,
    REDIRECT = 2'd3
  } stall_state_e;

  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  logic [XLEN-1:0] pcQ, pcD;
  logic [XLEN-1:0] idPcQ, idPcD;
  logic [31:0]     idInstQ, idInstD;
  logic            idValidQ, idValidD;
  stall_state_e    stateQ, stateD;
  logic [WDOG_W-1:0] wdogQ;
  logic            timeoutQ;
  logic            bubbleLoad;
  logic            redirect;

  // Redirect of the fetch PC and whether this cycle loads a bubble into IF/ID.
  always_comb begin
    redirect   = Wrong_prediction | JR_valid;
    bubbleLoad = Wrong_prediction | (IF_ID_Write & IF_ID_flush);
  end

  // Next fetch PC: mispredict beats jr, which beats normal sequential advance.
  always_comb begin
    pcD = pcQ;
    if (Wrong_prediction)  pcD = Branch_target;
    else if (JR_valid)     pcD = JR_target;
    else if (PC_Write)     pcD = pcQ + XLEN'(4);
  end

  // Next IF/ID contents; a mispredict squashes even while the buffer is held.
  always_comb begin
    idPcD    = idPcQ;
    idInstD  = idInstQ;
    idValidD = idValidQ;
    if (bubbleLoad) begin
      idInstD  = NOP_INST;
      idValidD = 1'b0;
    end else if (IF_ID_Write) begin
      idPcD    = pcQ;
      idInstD  = IF_inst;
      idValidD = 1'b1;
    end
  end

  // Stall-episode FSM; REDIRECT lasts one cycle and then decodes like RUN.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      RUN, REDIRECT: begin
        if (redirect)                     stateD = REDIRECT;
        else if (!PC_Write && !IF_ID_Write) stateD = STALL;
        else if (!PC_Write && IF_ID_flush)  stateD = JR_WAIT;
        else                              stateD = RUN;
      end
      STALL: begin
        if (Wrong_prediction) stateD = REDIRECT;
        else if (PC_Write)    stateD = RUN;
        else                  stateD = STALL;
      end
      JR_WAIT: begin
        if (redirect) stateD = REDIRECT;
        else          stateD = JR_WAIT;
      end
      default: stateD = RUN;
    endcase
  end

  // PC, IF/ID buffer and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ      <= RESET_PC;
      idPcQ    <= '0;
      idInstQ  <= NOP_INST;
      idValidQ <= 1'b0;
      stateQ   <= RUN;
    end else begin
      pcQ      <= pcD;
      idPcQ    <= idPcD;
      idInstQ  <= idInstD;
      idValidQ <= idValidD;
      stateQ   <= stateD;
    end
  end

  // Watchdog: counts consecutive cycles spent waiting and latches a sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdogQ    <= '0;
      timeoutQ <= 1'b0;
    end else if (stateQ == STALL || stateQ == JR_WAIT) begin
      if (wdogQ != WDOG_MAX) wdogQ <= wdogQ + 1'b1;
      if (wdogQ >= WDOG_MAX - 1'b1) timeoutQ <= 1'b1;
    end else begin
      wdogQ <= '0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  // Saturating counters of stalled fetch cycles and inserted bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (!PC_Write && !redirect && stallCntQ != '1) stallCntQ <= stallCntQ + 1'b1;
      if (bubbleLoad && flushCntQ != '1)            flushCntQ <= flushCntQ + 1'b1;
    end
  end

  assign Stall_count = stallCntQ;
  assign Flush_count = flushCntQ;
`else
  assign Stall_count = '0;
  assign Flush_count = '0;
`endif

  assign PC_out        = pcQ;
  assign ID_PC         = idPcQ;
  assign ID_inst       = idInstQ;
  assign ID_valid      = idValidQ;
  assign Stall_state   = stateQ;
  assign Stall_timeout = timeoutQ;

endmodule

// File: tb/tb_if_id_stall_buffer.sv
// Testbench for if_id_stall_buffer: a per-cycle vector table with hand-computed
// expectations, followed by hand-written watchdog sequences (WDOG_LIMIT = 4).
module tb_if_id_stall_buffer;

`ifdef PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pcWrite, ifIdWrite, ifIdFlush, wrongPred, jrValid;
  logic [31:0] branchTarget, jrTarget, ifInst;
  logic [31:0] pcOut, idPc, idInst;
  logic        idValid, stallTimeout;
  logic [1:0]  stallState;
  logic [15:0] stallCount, flushCount;

  int total = 0;
  int bad   = 0;
  string tag;

  typedef struct {
    logic        rst, pcw, ifw, flush, wp;
    logic [31:0] bt;
    logic        jrv;
    logic [31:0] jrt, inst;
    logic [31:0] ePc, eIdPc, eInst;
    logic        eValid;
    logic [1:0]  eState;
    int          eSc, eFc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  if_id_stall_buffer #(.WDOG_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .PC_Write(pcWrite), .IF_ID_Write(ifIdWrite),
    .IF_ID_flush(ifIdFlush), .Wrong_prediction(wrongPred),
    .Branch_target(branchTarget), .JR_valid(jrValid), .JR_target(jrTarget),
    .IF_inst(ifInst), .PC_out(pcOut), .ID_PC(idPc), .ID_inst(idInst),
    .ID_valid(idValid), .Stall_state(stallState), .Stall_timeout(stallTimeout),
    .Stall_count(stallCount), .Flush_count(flushCount)
  );

  // Adds one cycle of stimulus plus its expected post-edge outputs.
  task automatic addRow(input logic r, pcw, ifw, fl, wp, input logic [31:0] bt,
                        input logic jrv, input logic [31:0] jrt, inst,
                        input logic [31:0] ePc, eIdPc, eInst, input logic eValid,
                        input logic [1:0] eState, input int eSc, eFc);
    vec_t v;
    v.rst = r; v.pcw = pcw; v.ifw = ifw; v.flush = fl; v.wp = wp; v.bt = bt;
    v.jrv = jrv; v.jrt = jrt; v.inst = inst; v.ePc = ePc; v.eIdPc = eIdPc;
    v.eInst = eInst; v.eValid = eValid; v.eState = eState; v.eSc = eSc; v.eFc = eFc;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs, then waits for the edge and settles 1 time unit.
  task automatic applyStimulus(input logic r, pcw, ifw, fl, wp, input logic [31:0] bt,
                               input logic jrv, input logic [31:0] jrt, inst);
    rst = r; pcWrite = pcw; ifIdWrite = ifw; ifIdFlush = fl; wrongPred = wp;
    branchTarget = bt; jrValid = jrv; jrTarget = jrt; ifInst = inst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s %s got=%h expected=%h", tag, name, got, exp);
    end
  endtask

  initial begin
    // rst pcw ifw fl wp bt    jrv jrt   inst      | ePc   eIdPc  eInst  v st sc fc
    addRow(1,0,0,0,0,0,0,0,0,                  0,0,32'h13,0,0,0,0);
    addRow(1,0,0,0,0,0,0,0,0,                  0,0,32'h13,0,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'hA,              4,0,32'hA,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'hA,              8,4,32'hA,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'hA,              12,8,32'hA,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h1005,           16,12,32'h1005,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h1006,           20,16,32'h1006,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h1007,           24,20,32'h1007,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h1008,           28,24,32'h1008,1,0,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h1009,           32'h20,28,32'h1009,1,0,0,0);
    // load-use stall then release
    addRow(0,0,0,0,0,0,0,0,32'hDEAD,           32'h20,28,32'h1009,1,1,1,0);
    addRow(0,1,1,0,0,0,0,0,32'h2000,           32'h24,32'h20,32'h2000,1,0,1,0);
    // jr wait with flushes, then jr resolves
    addRow(0,0,1,1,0,0,0,0,32'h3000,           32'h24,32'h20,32'h13,0,2,2,1);
    addRow(0,0,1,1,0,0,0,0,32'h3000,           32'h24,32'h20,32'h13,0,2,3,2);
    addRow(0,0,1,1,0,0,0,0,32'h3000,           32'h24,32'h20,32'h13,0,2,4,3);
    addRow(0,0,1,0,0,0,1,32'h100,32'h4000,     32'h100,32'h24,32'h4000,1,3,4,3);
    addRow(0,1,1,0,0,0,0,0,32'h5000,           32'h104,32'h100,32'h5000,1,0,4,3);
    // mispredict during stall with simultaneous jr
    addRow(0,0,0,0,0,0,0,0,32'h5555,           32'h104,32'h100,32'h5000,1,1,5,3);
    addRow(0,0,0,0,1,32'h40,1,32'h80,32'h5555, 32'h40,32'h100,32'h13,0,3,5,4);
    addRow(0,1,1,0,0,0,0,0,32'h6000,           32'h44,32'h40,32'h6000,1,0,5,4);
    // jr during stall redirects PC but leaves the FSM in STALL
    addRow(0,0,0,0,0,0,0,0,32'h6666,           32'h44,32'h40,32'h6000,1,1,6,4);
    addRow(0,0,0,0,0,0,1,32'h200,32'h6666,     32'h200,32'h40,32'h6000,1,1,6,4);
    addRow(0,1,1,0,0,0,0,0,32'h7000,           32'h204,32'h200,32'h7000,1,0,6,4);
    // reset mid-stall discards everything
    addRow(0,0,0,0,0,0,0,0,32'h7777,           32'h204,32'h200,32'h7000,1,1,7,4);
    addRow(1,1,1,0,0,0,0,0,32'h7777,           0,0,32'h13,0,0,0,0);
    // PC wrap at the top of the address space
    addRow(0,1,1,0,0,0,1,32'hFFFFFFFC,32'h8000, 32'hFFFFFFFC,0,32'h8000,1,3,0,0);
    addRow(0,1,1,0,0,0,0,0,32'h9000,           0,32'hFFFFFFFC,32'h9000,1,0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].flush, vecs[i].wp,
                    vecs[i].bt, vecs[i].jrv, vecs[i].jrt, vecs[i].inst);
      tag = $sformatf("row%0d", i);
      checkOutput("PC_out", pcOut, vecs[i].ePc);
      checkOutput("ID_PC", idPc, vecs[i].eIdPc);
      checkOutput("ID_inst", idInst, vecs[i].eInst);
      checkOutput("ID_valid", {31'b0, idValid}, {31'b0, vecs[i].eValid});
      checkOutput("Stall_state", {30'b0, stallState}, {30'b0, vecs[i].eState});
      checkOutput("Stall_timeout", {31'b0, stallTimeout}, 32'b0);
      checkOutput("Stall_count", {16'b0, stallCount}, PerfEn ? 32'(vecs[i].eSc) : 32'b0);
      checkOutput("Flush_count", {16'b0, flushCount}, PerfEn ? 32'(vecs[i].eFc) : 32'b0);
    end

    // Watchdog just below the limit: three stalled cycles must not trip it.
    tag = "wdog3";
    applyStimulus(1,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) applyStimulus(0,0,0,0,0,0,0,0,0);
    applyStimulus(0,1,1,0,0,0,0,0,0);
    applyStimulus(0,1,1,0,0,0,0,0,0);
    checkOutput("Stall_timeout", {31'b0, stallTimeout}, 32'b0);

    // Watchdog at the limit: four stalled cycles trip it, and it stays set.
    tag = "wdog4";
    for (int k = 0; k < 4; k++) applyStimulus(0,0,0,0,0,0,0,0,0);
    checkOutput("Stall_timeout_pre", {31'b0, stallTimeout}, 32'b0);
    applyStimulus(0,1,1,0,0,0,0,0,0);
    checkOutput("Stall_timeout", {31'b0, stallTimeout}, 32'b1);
    checkOutput("Stall_state", {30'b0, stallState}, 32'd0);
    applyStimulus(0,1,1,0,0,0,0,0,0);
    applyStimulus(0,1,1,0,0,0,0,0,0);
    checkOutput("Stall_timeout_sticky", {31'b0, stallTimeout}, 32'b1);

    // Waiting in JR_WAIT also feeds the watchdog; reset clears the flag first.
    tag = "wdogJr";
    applyStimulus(1,0,0,0,0,0,0,0,0);
    checkOutput("Stall_timeout_rst", {31'b0, stallTimeout}, 32'b0);
    for (int k = 0; k < 5; k++) applyStimulus(0,0,1,1,0,0,0,0,0);
    checkOutput("Stall_state", {30'b0, stallState}, 32'd2);
    checkOutput("Stall_timeout", {31'b0, stallTimeout}, 32'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
